// File: rtl/decode_sb.sv
// decode_sb: RV32 decode stage with register scoreboard.
// Sits between fetch and execute. It classifies the fetched instruction,
// reads the register file combinationally and tracks the destination
// registers of instructions that are in flight. Fetch is stalled on RAW
// and WAW hazards. Writeback ports release reservations. When BYPASS is
// set, a writeback in the same cycle can supply a source operand.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   valid_i/ready_o          fetch handshake (pc_i, inst_i)
//   rs1num_o/rs2num_o        register file read addresses
//   rs1data_i/rs2data_i      register file read data (combinational)
//   wb_valid_i/wb_rd_i/wb_data_i  NWB writeback/release ports, packed per port
//   flush_i                  kills the decoded slot and drops the input slot
//   valid_ro/ready_i         execute handshake (pc_ro, inst_ro, rsNdata_ro)
//   rdvalid_ro               decoded slot holds a reservation on inst_ro[11:7]
//   busy_o                   scoreboard bit vector
module decode_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NWB    = 2,
  parameter int BYPASS = 1,
  localparam int RAW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [XLEN-1:0]     pc_i,
  input  logic [31:0]         inst_i,
  output logic [RAW-1:0]      rs1num_o,
  output logic [RAW-1:0]      rs2num_o,
  input  logic [XLEN-1:0]     rs1data_i,
  input  logic [XLEN-1:0]     rs2data_i,
  input  logic [NWB-1:0]      wb_valid_i,
  input  logic [NWB*RAW-1:0]  wb_rd_i,
  input  logic [NWB*XLEN-1:0] wb_data_i,
  input  logic                flush_i,
  output logic                valid_ro,
  input  logic                ready_i,
  output logic [XLEN-1:0]     pc_ro,
  output logic [31:0]         inst_ro,
  output logic [XLEN-1:0]     rs1data_ro,
  output logic [XLEN-1:0]     rs2data_ro,
  output logic                rdvalid_ro,
  output logic [NREG-1:0]     busy_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic BYPASS_EN = (BYPASS != 0);

  logic [6:0]      opcode;
  logic [RAW-1:0]  rs1, rs2, rd;
  logic            uses_rs1, uses_rs2, writes_rd, rd_res;
  logic            hit1, hit2, hitd;
  logic [XLEN-1:0] byp1, byp2, op1, op2;
  logic            raw1, raw2, waw, hazard, cke, issue;
  logic [NREG-1:0] busy, busy_next;

  assign opcode   = inst_i[6:0];
  assign rd       = inst_i[7 +: RAW];
  assign rs1      = inst_i[15 +: RAW];
  assign rs2      = inst_i[20 +: RAW];
  assign rs1num_o = rs1;
  assign rs2num_o = rs2;
  assign busy_o   = busy;

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
      default: ;
    endcase
  end

  assign rd_res = writes_rd && (rd != '0);

  // Scan from the highest port down so the lowest matching port is the
  // last assignment and therefore wins.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    hitd = 1'b0;
    byp1 = '0;
    byp2 = '0;
    for (int j = NWB - 1; j >= 0; j--) begin
      if (wb_valid_i[j] && (wb_rd_i[j*RAW +: RAW] == rs1) && (rs1 != '0)) begin
        hit1 = 1'b1;
        byp1 = wb_data_i[j*XLEN +: XLEN];
      end
      if (wb_valid_i[j] && (wb_rd_i[j*RAW +: RAW] == rs2) && (rs2 != '0)) begin
        hit2 = 1'b1;
        byp2 = wb_data_i[j*XLEN +: XLEN];
      end
      if (wb_valid_i[j] && (wb_rd_i[j*RAW +: RAW] == rd) && (rd != '0)) begin
        hitd = 1'b1;
      end
    end
  end

  // busy[0] is held at zero, so x0 sources never raise a hazard.
  assign raw1   = uses_rs1 && busy[rs1] && !(BYPASS_EN && hit1);
  assign raw2   = uses_rs2 && busy[rs2] && !(BYPASS_EN && hit2);
  assign waw    = rd_res && busy[rd] && !hitd;
  assign hazard = raw1 || raw2 || waw;

  assign cke     = !valid_ro || ready_i;
  assign ready_o = flush_i || (cke && !hazard);
  assign issue   = valid_i && !flush_i && cke && !hazard;

  assign op1 = (BYPASS_EN && hit1) ? byp1 : rs1data_i;
  assign op2 = (BYPASS_EN && hit2) ? byp2 : rs2data_i;

  // Later assignments take precedence: writeback clear, then flush
  // release, then the new reservation.
  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NWB; j++) begin
      if (wb_valid_i[j]) busy_next[wb_rd_i[j*RAW +: RAW]] = 1'b0;
    end
    if (flush_i && valid_ro && rdvalid_ro) busy_next[inst_ro[7 +: RAW]] = 1'b0;
    if (issue && rd_res) busy_next[rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      valid_ro   <= 1'b0;
      rdvalid_ro <= 1'b0;
      pc_ro      <= '0;
      inst_ro    <= '0;
      rs1data_ro <= '0;
      rs2data_ro <= '0;
    end else begin
      busy <= busy_next;
      if (cke || flush_i) begin
        valid_ro   <= issue;
        rdvalid_ro <= issue && rd_res;
      end
      if (cke) begin
        pc_ro      <= pc_i;
        inst_ro    <= inst_i;
        rs1data_ro <= op1;
        rs2data_ro <= op2;
      end
    end
  end

endmodule

// File: doc/decode_sb.md
Name: decode_sb

Overview:
- Parametrised RV32 decode stage with an integrated register scoreboard, multi-port writeback release and optional writeback-to-operand bypass.
- Sits between fetch and execute and reads the register file combinationally.
- Stalls fetch on RAW and WAW hazards.
- Supports a pipeline flush that kills the decoded slot and returns its reservation.

Parameters:
- XLEN, 32, data/pc/register width.
- NREG, 32, architectural register count (16 for RV32E); RAW = clog2(NREG).
- NWB, 2, number of writeback/release ports.
- BYPASS, 1, 1 = a same-cycle writeback to a busy source satisfies the hazard and supplies the operand.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- valid_i  in  1  fetch slot valid
- ready_o  out  1  decode accepts the fetch slot this cycle
- pc_i  in  XLEN  fetch pc
- inst_i  in  32  fetch instruction
- rs1num_o  out  RAW  register file read address 0 (inst_i[19:15])
- rs2num_o  out  RAW  register file read address 1 (inst_i[24:20])
- rs1data_i  in  XLEN  register file read data 0, combinational
- rs2data_i  in  XLEN  register file read data 1, combinational
- wb_valid_i  in  NWB  writeback port j valid
- wb_rd_i  in  NWB*RAW  writeback port j destination (port j at [j*RAW +: RAW])
- wb_data_i  in  NWB*XLEN  writeback port j data
- flush_i  in  1  kill younger instructions (branch taken / redirect)
- valid_ro  out  1  decoded slot valid
- ready_i  in  1  execute accepts the decoded slot
- pc_ro  out  XLEN  decoded pc
- inst_ro  out  32  decoded instruction
- rs1data_ro  out  XLEN  operand 1
- rs2data_ro  out  XLEN  operand 2
- rdvalid_ro  out  1  decoded slot holds a reservation on inst_ro[11:7]
- busy_o  out  NREG  scoreboard bit vector, for debug and verification

Behaviour:
- Reset: valid_ro, rdvalid_ro, pc_ro, inst_ro, rs1data_ro, rs2data_ro and busy_o are all 0. Reset asserted mid-operation drops all reservations immediately.
- Classification by opcode (inst_i[6:0]):
  - OP 0110011 reads rs1 and rs2, writes rd.
  - OPIMM 0010011, LOAD 0000011 and JALR 1100111 read rs1, write rd.
  - STORE 0100011 and BRANCH 1100011 read rs1 and rs2.
  - LUI 0110111, AUIPC 0010111 and JAL 1101111 write rd.
  - Any other opcode reads nothing, writes nothing, and passes through.
- Register x0 is never busy, never reserved and never bypassed. Register numbers are truncated to RAW bits.
- wbhit(r): some wb_valid_i[j] is set with wb_rd_i[j]==r and r!=0. On multiple hits the lowest j wins.
- Hazards:
  - RAW on a source: the register is read, busy[rs] is set, and !(BYPASS & wbhit(rs)).
  - WAW on the destination: the instruction writes rd, rd!=0, busy[rd] is set, and !wbhit(rd). The WAW stall guarantees at most one outstanding writer per register.
- cke = ~valid_ro | ready_i.
- ready_o = flush_i | (cke & ~hazard).
- issue = valid_i & ~flush_i & cke & ~hazard.
- Pipeline register (1-cycle latency), updated when cke | flush_i:
  - valid_ro <= issue.
  - pc_ro/inst_ro are loaded whenever cke.
  - rdvalid_ro <= issue & writes_rd & rd!=0.
  - Operand = wb_data of the winning port if BYPASS & wbhit, else rsNdata_i.
- A stall (hazard with cke=1) produces a bubble: valid_ro=0. Upstream holds pc_i/inst_i.
- Flush:
  - flush_i has priority over ready_i. The decoded slot is killed (valid_ro <= 0) even if ready_i=1 that cycle, and execute ignores that handoff.
  - A valid input that cycle is consumed (ready_o=1) and discarded.
  - If valid_ro & rdvalid_ro, busy[inst_ro[11:7]] is released.
- Scoreboard update per cycle, in order:
  1. Clear busy[wb_rd_i[j]] for every valid port.
  2. Clear the flush release.
  3. Set busy[rd] on issue with rdvalid.
  - Set wins over a same-cycle clear of the same register.
- A writeback to a non-busy register is harmless (clears nothing).

Test Plan:
- Reset, then issue `addi x5,x0,1` (0x00100293) with valid_i=1, ready_i=1 -> the next cycle has valid_ro=1, rdvalid_ro=1 and busy_o[5]=1; ready_o was 1.
- With busy[5]=1, present `add x6,x5,x5` and no writeback -> ready_o=0, valid_ro=0 while stalled. Then assert wb_valid_i[1]=1, wb_rd_i[1]=5, wb_data=0x1234 with BYPASS=1 -> accepted that cycle, rs1data_ro=rs2data_ro=0x1234, busy_o[5]=0 and busy_o[6]=1.
- Repeat the previous scenario with BYPASS=0 -> stalls on the writeback cycle and issues the next cycle using rs1data_i.
- busy[7]=1, present `lui x7,1` -> stalls (WAW). When the port 0 writeback of x7 arrives in the same cycle, it issues and busy_o[7] stays 1 (set wins).
- Decoded slot `addi x9,...` valid with busy[9]=1, assert flush_i with ready_i=1 and a valid input -> next cycle valid_ro=0, busy_o[9]=0, ready_o was 1, and the input was discarded.
- Instruction `addi x0,x0,0` and store `sw x3,0(x2)` -> rdvalid_ro=0 and busy_o is unchanged. ready_i=0 with valid_ro=1 -> all outputs hold and ready_o=0.
